// File: rtl/sliding_window_kxk.sv
// rtl/sliding_window_kxk.sv - KxK sliding window generator with line buffers, stride and backpressure

module sliding_window_kxk #(
   parameter int DATA_W = 8,
   parameter int K      = 3,
   parameter int IMG_W  = 5,
   parameter int IMG_H  = 5,
   parameter int STRIDE = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        pixel_in,
   output logic [K*K*DATA_W-1:0]    win,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(IMG_H)-1:0] out_row,
   output logic [$clog2(IMG_W)-1:0] out_col,
   output logic                     frame_done
);

   localparam int RW = $clog2(IMG_H);
   localparam int CW = $clog2(IMG_W);
   localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
   localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
   // Bottom-right position of the final window of a frame once stride skips the ragged edge
   localparam logic [RW-1:0] DONE_ROW  = RW'(IMG_H - 1 - ((IMG_H - K) % STRIDE));
   localparam logic [CW-1:0] DONE_COL  = CW'(IMG_W - 1 - ((IMG_W - K) % STRIDE));
   localparam logic [PW-1:0] PH_MAX    = PW'(STRIDE - 1);

   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic [PW-1:0] rph_q, rph_d;
   logic [PW-1:0] cph_q, cph_d;

   logic                  out_valid_q, out_valid_d;
   logic [K*K*DATA_W-1:0] win_q, win_d;
   logic [RW-1:0]         out_row_q, out_row_d;
   logic [CW-1:0]         out_col_q, out_col_d;
   logic                  frame_done_q, frame_done_d;

   logic accept;
   logic emit;

   logic [DATA_W-1:0]     new_col [K];
   logic [DATA_W-1:0]     sr_q [K][K];
   logic [DATA_W-1:0]     sr_d [K][K];
   logic [DATA_W-1:0]     lb_q [K-1][IMG_W];
   logic [K*K*DATA_W-1:0] win_flat;

   // Single output register without skid: take a pixel only when the output slot is free or draining
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign emit     = accept && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST)
                     && (rph_q == '0) && (cph_q == '0);

   // Next window: shift left one column, new rightmost column from line buffers plus incoming pixel
   always_comb begin
      for (int r = 0; r < K-1; r++) begin
         new_col[r] = lb_q[r][col_q];
      end
      new_col[K-1] = pixel_in;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K-1; c++) begin
            sr_d[r][c] = sr_q[r][c+1];
         end
         sr_d[r][K-1] = new_col[r];
      end
      win_flat = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            win_flat[(r*K+c)*DATA_W +: DATA_W] = sr_d[r][c];
         end
      end
   end

   // Raster position and stride phases; a phase of 0 marks a row/column where a window may start
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      rph_d = rph_q;
      cph_d = cph_q;
      if (accept) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            cph_d = '0;
            if (row_q == ROW_LAST) begin
               row_d = '0;
               rph_d = '0;
            end else begin
               row_d = row_q + 1'b1;
               rph_d = ((row_q < ROW_FIRST) || (rph_q == PH_MAX)) ? '0 : rph_q + 1'b1;
            end
         end else begin
            col_d = col_q + 1'b1;
            cph_d = ((col_q < COL_FIRST) || (cph_q == PH_MAX)) ? '0 : cph_q + 1'b1;
         end
      end
   end

   // Output slot: a new window overwrites a draining one, otherwise hold until accepted
   always_comb begin
      out_valid_d  = emit ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
      win_d        = emit ? win_flat : win_q;
      out_row_d    = emit ? row_q : out_row_q;
      out_col_d    = emit ? col_q : out_col_q;
      frame_done_d = out_valid_q && out_ready && (out_row_q == DONE_ROW) && (out_col_q == DONE_COL);
   end

   // Control and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_q        <= '0;
         col_q        <= '0;
         rph_q        <= '0;
         cph_q        <= '0;
         out_valid_q  <= 1'b0;
         win_q        <= '0;
         out_row_q    <= '0;
         out_col_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         row_q        <= row_d;
         col_q        <= col_d;
         rph_q        <= rph_d;
         cph_q        <= cph_d;
         out_valid_q  <= out_valid_d;
         win_q        <= win_d;
         out_row_q    <= out_row_d;
         out_col_q    <= out_col_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Window array and line-buffer cascade; contents need no reset since emits only use current-frame data
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               sr_q[r][c] <= sr_d[r][c];
            end
         end
         for (int r = 0; r < K-2; r++) begin
            lb_q[r][col_q] <= lb_q[r+1][col_q];
         end
         lb_q[K-2][col_q] <= pixel_in;
      end
   end

   assign out_valid  = out_valid_q;
   assign win        = win_q;
   assign out_row    = out_row_q;
   assign out_col    = out_col_q;
   assign frame_done = frame_done_q;

endmodule
